// File: rtl/em_skid_stage.sv
// em_skid_stage: execute-to-memory pipeline register with a one-entry skid
// buffer. in_ready is decoded from registered state only, which breaks the
// combinational ready path from downstream. Write controls are forced to
// zero on bubbles so that an invalid slot can never write the regfile or memory.
module em_skid_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_qb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_qb,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Entry packing, MSB to LSB: {ctrl, rd, r, qb}
    localparam int unsigned ENT_W = CTRL_W + RD_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   main_q, main_d;
    logic [ENT_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [ENT_W-1:0]   in_ent;

    assign in_ent    = {in_ctrl, in_rd, in_r, in_qb};
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);

    assign out_qb    = main_q[DATA_W-1:0];
    assign out_r     = main_q[2*DATA_W-1:DATA_W];
    assign out_rd    = main_q[2*DATA_W+RD_W-1:2*DATA_W];
    // Controls gated by validity so a bubble reads as all-zero writes
    assign out_ctrl  = out_valid ? main_q[ENT_W-1:2*DATA_W+RD_W] : '0;
    assign stall_cnt = stall_cnt_q;

    // Next-state and entry-movement decode
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Any out transfer this cycle is considered completed; stage empties
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_d = ST_ONE;
                        main_d  = in_ent;
                    end
                end
                ST_ONE: begin
                    if (in_valid && out_ready) begin
                        main_d = in_ent;
                    end else if (in_valid) begin
                        state_d = ST_FULL;
                        skid_d  = in_ent;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Saturating count of back-pressured cycles; frozen on a flush cycle
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!flush && out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, payload and counter registers; reset overrides everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_em_skid_stage.sv
// Directed and scoreboard bench for em_skid_stage (64-bit payload instance
// plus a CNT_W=4 instance for counter saturation).
module tb_em_skid_stage;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [2:0]  in_ctrl, out_ctrl;
    logic [4:0]  in_rd, out_rd;
    logic [63:0] in_r, in_qb, out_r, out_qb;
    logic [15:0] stall_cnt;

    logic        in_ready4, out_valid4;
    logic [2:0]  out_ctrl4;
    logic [4:0]  out_rd4;
    logic [31:0] out_r4, out_qb4;
    logic [3:0]  stall_cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    em_skid_stage #(.DATA_W(64), .RD_W(5), .CTRL_W(3), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_r(in_r), .in_qb(in_qb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_r(out_r), .out_qb(out_qb),
        .stall_cnt(stall_cnt)
    );

    em_skid_stage #(.DATA_W(32), .RD_W(5), .CTRL_W(3), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_r(in_r[31:0]), .in_qb(in_qb[31:0]),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_ctrl(out_ctrl4), .out_rd(out_rd4), .out_r(out_r4), .out_qb(out_qb4),
        .stall_cnt(stall_cnt4)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic drive(input logic [2:0] c, input logic [4:0] rd,
                         input logic [63:0] r, input logic [63:0] qb);
        in_ctrl = c; in_rd = rd; in_r = r; in_qb = qb;
    endtask

    task automatic test_reset();
        drive(3'b111, 5'd31, '1, '1);
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_cmp++; if ({out_ctrl, out_rd} !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl_rd: got %h want 00", {out_ctrl, out_rd}); end
        n_cmp++; if ({out_r, out_qb} !== 128'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {out_r, out_qb}); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        drive(3'b101, 5'd7, 64'h0000_0000_1234_5678, 64'hFEDC_BA98_7654_3210);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_ctrl !== 3'b101) begin n_bad++; $display("FAIL single_ctrl: got %b want 101", out_ctrl); end
        n_cmp++; if (out_rd !== 5'd7) begin n_bad++; $display("FAIL single_rd: got %0d want 7", out_rd); end
        n_cmp++; if (out_r !== 64'h0000_0000_1234_5678) begin n_bad++; $display("FAIL single_r: got %h want 12345678", out_r); end
        n_cmp++; if (out_qb !== 64'hFEDC_BA98_7654_3210) begin n_bad++; $display("FAIL single_qb: got %h want fedcba9876543210", out_qb); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== 3'b000) begin n_bad++; $display("FAIL bubble_ctrl: got %b want 000", out_ctrl); end
        n_cmp++; if (out_rd !== 5'd7 || out_r !== 64'h0000_0000_1234_5678) begin n_bad++; $display("FAIL bubble_hold: got rd=%0d r=%h want rd=7 r=12345678", out_rd, out_r); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL single_stall: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(3'b100, 5'd1, 64'hAAAA_0000_0000_000A, 64'h1); in_valid = 1'b1; out_ready = 1'b1;
        step();
        drive(3'b010, 5'd2, 64'hBBBB_0000_0000_000B, 64'h2); out_ready = 1'b0;
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_r !== 64'hAAAA_0000_0000_000A) begin n_bad++; $display("FAIL b2b_head_A: got %h want A", out_r); end
        drive(3'b001, 5'd3, 64'hCCCC_0000_0000_000C, 64'h3);
        step();
        n_cmp++; if (in_ready !== 1'b0 || out_r !== 64'hAAAA_0000_0000_000A) begin n_bad++; $display("FAIL b2b_hold: got rdy=%b r=%h want rdy=0 r=A", in_ready, out_r); end
        n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL b2b_stall: got %0d want 2", stall_cnt); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_r !== 64'hBBBB_0000_0000_000B || out_ctrl !== 3'b010 || out_rd !== 5'd2) begin n_bad++; $display("FAIL b2b_second_B: got r=%h c=%b rd=%0d want B/010/2", out_r, out_ctrl, out_rd); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_back: got %b want 1", in_ready); end
        step();
        n_cmp++; if (out_r !== 64'hCCCC_0000_0000_000C || out_ctrl !== 3'b001 || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_third_C: got r=%h c=%b v=%b want C/001/1", out_r, out_ctrl, out_valid); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(3'b111, 5'd4, 64'h1111, 64'h0); in_valid = 1'b1; out_ready = 1'b0;
        step();
        drive(3'b111, 5'd5, 64'h2222, 64'h0);
        step();
        n_cmp++; if (in_ready !== 1'b0 || stall_cnt !== 16'd1) begin n_bad++; $display("FAIL flush_prefull: got rdy=%b cnt=%0d want 0/1", in_ready, stall_cnt); end
        drive(3'b111, 5'd6, 64'h3333, 64'h0); flush = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got v=%b c=%b rdy=%b want 0/000/1", out_valid, out_ctrl, in_ready); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL flush_stall_frozen: got %0d want 1", stall_cnt); end
        flush = 1'b0; drive(3'b011, 5'd9, 64'h4444, 64'h5); out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_r !== 64'h4444 || out_rd !== 5'd9) begin n_bad++; $display("FAIL flush_after: got v=%b r=%h rd=%0d want 1/4444/9", out_valid, out_r, out_rd); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_stale: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_full();
        do_reset();
        drive(3'b110, 5'd10, 64'h5555, 64'h6); in_valid = 1'b1; out_ready = 1'b0;
        step(); step();
        in_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 3'b000) begin n_bad++; $display("FAIL rstfull_ctrl: got v=%b rdy=%b c=%b want 0/1/000", out_valid, in_ready, out_ctrl); end
        n_cmp++; if (out_rd !== 5'd0 || out_r !== 64'h0 || out_qb !== 64'h0 || stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rstfull_data: got rd=%0d r=%h qb=%h cnt=%0d want zeros", out_rd, out_r, out_qb, stall_cnt); end
        out_ready = 1'b1;
        step(); step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstfull_no_stale: got %b want 0", out_valid); end
    endtask

    task automatic test_stall_sat();
        do_reset();
        drive(3'b101, 5'd12, 64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222);
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) step();
        n_cmp++; if (stall_cnt4 !== 4'd14) begin n_bad++; $display("FAIL sat_14: got %0d want 14", stall_cnt4); end
        step();
        n_cmp++; if (stall_cnt4 !== 4'd15) begin n_bad++; $display("FAIL sat_15: got %0d want 15", stall_cnt4); end
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (stall_cnt4 !== 4'd15) begin n_bad++; $display("FAIL sat_hold: got %0d want 15", stall_cnt4); end
        n_cmp++; if (stall_cnt !== 16'd20) begin n_bad++; $display("FAIL sat_wide: got %0d want 20", stall_cnt); end
        n_cmp++; if (out_valid4 !== 1'b1 || in_ready4 !== 1'b1 || out_ctrl4 !== 3'b101 || out_rd4 !== 5'd12) begin n_bad++; $display("FAIL sat_ctl4: got v=%b rdy=%b c=%b rd=%0d want 1/1/101/12", out_valid4, in_ready4, out_ctrl4, out_rd4); end
        n_cmp++; if (out_r4 !== 32'h7777_6666 || out_qb4 !== 32'h3333_2222) begin n_bad++; $display("FAIL sat_data4: got r=%h qb=%h want 77776666/33332222", out_r4, out_qb4); end
    endtask

    task automatic test_random();
        logic [135:0] sb[$];
        logic [135:0] exp_ent;
        logic [63:0]  seq;
        int unsigned  exp_stall;
        do_reset();
        seq = 64'h0123_0000_0000_0000;
        exp_stall = 0;
        for (int i = 0; i < 3000 + 8; i++) begin
            if (i < 3000) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            drive(3'($urandom_range(1, 7)), 5'($urandom), seq, {$urandom, $urandom});
            if (!out_valid) begin
                n_cmp++; if (out_ctrl !== 3'b000) begin n_bad++; $display("FAIL rnd_bubble_ctrl: cycle %0d got %b want 000", i, out_ctrl); end
            end
            if (out_valid && !out_ready) exp_stall++;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL rnd_extra: cycle %0d got r=%h want no entry", i, out_r);
                end else begin
                    exp_ent = sb.pop_front();
                    if ({out_ctrl, out_rd, out_r, out_qb} !== exp_ent) begin
                        n_bad++; $display("FAIL rnd_entry: cycle %0d got %h want %h", i, {out_ctrl, out_rd, out_r, out_qb}, exp_ent);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({in_ctrl, in_rd, in_r, in_qb});
                seq = seq + 1;
            end
            step();
        end
        n_cmp++; if (sb.size() != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_drain: got left=%0d v=%b want 0/0", sb.size(), out_valid); end
        n_cmp++; if (stall_cnt !== 16'(exp_stall)) begin n_bad++; $display("FAIL rnd_stall: got %0d want %0d", stall_cnt, exp_stall); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive('0, '0, '0, '0);
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_reset_full();
        test_stall_sat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
